serial_word_tx: RTL and testbench

//  Parallel-to-serial transmitter. Takes a DATA_W-bit word through a valid/ready

---
 rtl/serial_word_tx.sv | 159 +++++++++++++++
 tb/tb_serial_word_tx.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_word_tx.sv
// Parallel-to-serial frame transmitter: start, DATA_W bits LSB first, stop.
// Define SERIAL_TX_PARITY_EN to insert an even-parity bit before the stop bit.
module serial_word_tx #(
  parameter int DATA_W       = 8,
  parameter int CLKS_PER_BIT = 16
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              ena,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic              tx_line,
  output logic              busy
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int BW = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(DATA_W - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t            r_state;
  state_t            w_state;
  logic [CW-1:0]     r_cnt;
  logic [CW-1:0]     w_cnt;
  logic [BW-1:0]     r_bit;
  logic [BW-1:0]     w_bit;
  logic [DATA_W-1:0] r_shift;
  logic [DATA_W-1:0] w_shift;
  logic              r_line;
  logic              w_line;
  logic              r_busy;
  logic              w_busy;
  logic              w_tick;
  logic              w_accept;
`ifdef SERIAL_TX_PARITY_EN
  logic              r_par;
  logic              w_par;
`endif

  assign tx_ready = (r_state == S_IDLE) && ena;
  assign tx_line  = r_line;
  assign busy     = r_busy;

  // Next-state, bit timing and serial output selection
  always_comb begin
    w_state  = r_state;
    w_cnt    = r_cnt;
    w_bit    = r_bit;
    w_shift  = r_shift;
    w_line   = r_line;
    w_busy   = r_busy;
`ifdef SERIAL_TX_PARITY_EN
    w_par    = r_par;
`endif
    w_tick   = (r_cnt == CNT_LAST);
    w_accept = tx_valid && tx_ready;

    if (r_state != S_IDLE) begin
      w_cnt = w_tick ? '0 : r_cnt + CW'(1);
    end

    unique case (r_state)
      S_IDLE: begin
        w_cnt = '0;
        if (w_accept) begin
          w_state = S_START;
          w_shift = tx_data;
          w_bit   = '0;
          w_line  = 1'b0;
          w_busy  = 1'b1;
`ifdef SERIAL_TX_PARITY_EN
          w_par   = ^tx_data;
`endif
        end
      end
      S_START: begin
        if (w_tick) begin
          w_state = S_DATA;
          w_bit   = '0;
          w_line  = r_shift[0];
        end
      end
      S_DATA: begin
        if (w_tick) begin
          if (r_bit == BIT_LAST) begin
`ifdef SERIAL_TX_PARITY_EN
            w_state = S_PARITY;
            w_line  = r_par;
`else
            w_state = S_STOP;
            w_line  = 1'b1;
`endif
          end else begin
            w_shift = r_shift >> 1;
            w_line  = w_shift[0];
            w_bit   = r_bit + BW'(1);
          end
        end
      end
`ifdef SERIAL_TX_PARITY_EN
      S_PARITY: begin
        if (w_tick) begin
          w_state = S_STOP;
          w_line  = 1'b1;
        end
      end
`endif
      S_STOP: begin
        if (w_tick) begin
          w_state = S_IDLE;
          w_line  = 1'b1;
          w_busy  = 1'b0;
        end
      end
      default: begin
        w_state = S_IDLE;
        w_cnt   = '0;
        w_line  = 1'b1;
        w_busy  = 1'b0;
      end
    endcase
  end

  // State register; everything freezes while ena is low
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_bit   <= '0;
      r_shift <= '0;
      r_line  <= 1'b1;
      r_busy  <= 1'b0;
`ifdef SERIAL_TX_PARITY_EN
      r_par   <= 1'b0;
`endif
    end else if (ena) begin
      r_state <= w_state;
      r_cnt   <= w_cnt;
      r_bit   <= w_bit;
      r_shift <= w_shift;
      r_line  <= w_line;
      r_busy  <= w_busy;
`ifdef SERIAL_TX_PARITY_EN
      r_par   <= w_par;
`endif
    end
  end

endmodule

// File: tb/tb_serial_word_tx.sv
// Scoreboard bench for serial_word_tx (DATA_W=8, CLKS_PER_BIT=4).
// Monitor rebuilds frames from tx_line, counting only enabled cycles.
module tb_serial_word_tx;

  localparam int DW  = 8;
  localparam int CPB = 4;
`ifdef SERIAL_TX_PARITY_EN
  localparam int FB  = DW + 3;
`else
  localparam int FB  = DW + 2;
`endif

  logic          clk;
  logic          clr;
  logic          ena;
  logic [DW-1:0] tx_data;
  logic          tx_valid;
  logic          tx_ready;
  logic          tx_line;
  logic          busy;

  int vectors;
  int miscompares;
  int sent;
  int done;

  logic [FB-1:0] exp_q[$];

  bit            in_fr;
  int            n_smp;
  int            gap;
  int            last_gap;
  bit            glitch;
  bit            busy_lo;
  logic [FB-1:0] bits;
  logic [FB-1:0] last_bits;

  serial_word_tx #(
    .DATA_W      (DW),
    .CLKS_PER_BIT(CPB)
  ) dut (
    .clk     (clk),
    .clr     (clr),
    .ena     (ena),
    .tx_data (tx_data),
    .tx_valid(tx_valid),
    .tx_ready(tx_ready),
    .tx_line (tx_line),
    .busy    (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp,
               $time);
    end
  endtask

  // Reference frame: bit i is the i-th bit on the line
  function automatic logic [FB-1:0] frame_of(input logic [DW-1:0] d);
    logic [FB-1:0] f;
    f    = '0;
    f[0] = 1'b0;
    for (int i = 0; i < DW; i++) f[1+i] = d[i];
`ifdef SERIAL_TX_PARITY_EN
    f[DW+1] = ^d;
`endif
    f[FB-1] = 1'b1;
    return f;
  endfunction

  // Monitor: rebuild frames, compare against the scoreboard queue
  always @(negedge clk) begin
    if (clr) begin
      in_fr = 1'b0;
      n_smp = 0;
      gap   = 0;
    end else if (ena) begin
      if (!in_fr) begin
        if (tx_line == 1'b0) begin
          in_fr    = 1'b1;
          n_smp    = 0;
          bits     = '0;
          glitch   = 1'b0;
          busy_lo  = 1'b0;
          last_gap = gap;
          gap      = 0;
        end else begin
          gap++;
        end
      end
      if (in_fr) begin
        if (n_smp % CPB == 0) bits[n_smp/CPB] = tx_line;
        else if (tx_line != bits[n_smp/CPB]) glitch = 1'b1;
        if (!busy) busy_lo = 1'b1;
        n_smp++;
        if (n_smp == FB * CPB) begin
          in_fr     = 1'b0;
          last_bits = bits;
          done++;
          if (exp_q.size() == 0) begin
            chk("frame_unexpected", 32'(bits), 32'h0);
          end else begin
            chk("frame_bits", 32'(bits), 32'(exp_q[0]));
            chk("frame_shape", {glitch, busy_lo}, 2'b00);
            exp_q.delete(0);
          end
        end
      end
    end
  end

  task automatic send(input logic [DW-1:0] d, input bit keep);
    int t;
    tx_data  = d;
    tx_valid = 1'b1;
    t = 0;
    while (!tx_ready && t < 1000) begin
      @(posedge clk);
      #1;
      t++;
    end
    if (!tx_ready) begin
      chk("accept_timeout", 32'd0, 32'd1);
      tx_valid = 1'b0;
      return;
    end
    exp_q.push_back(frame_of(d));
    sent++;
    @(posedge clk);
    #1;
    chk("accept_start", {busy, tx_line}, 2'b10);
    if (!keep) tx_valid = 1'b0;
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (busy && n < 500);
    if (busy) chk("idle_timeout", 32'd1, 32'd0);
  endtask

  int  lat;
  int  t;
  bit  keep;

  initial begin
    vectors     = 0;
    miscompares = 0;
    sent        = 0;
    done        = 0;
    in_fr       = 1'b0;
    gap         = 0;
    last_gap    = -1;
    clr         = 1'b0;
    ena         = 1'b1;
    tx_valid    = 1'b0;
    tx_data     = '0;

    // asynchronous reset between edges
    @(posedge clk);
    #2 clr = 1'b1;
    #1;
    chk("rst_line", tx_line, 1'b1);
    chk("rst_busy", busy, 1'b0);
    chk("rst_ready", tx_ready, 1'b1);
    repeat (2) @(posedge clk);
    #1 clr = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // single frame latency
    send(8'hA5, 1'b0);
    wait_idle(lat);
    chk("lat_a5", lat, FB * CPB);
    chk("ready_after_a5", tx_ready, 1'b1);
    repeat (3) @(posedge clk);
    #1;

    // back-to-back with tx_valid held high
    send(8'h00, 1'b1);
    send(8'hFF, 1'b0);
    @(negedge clk);
    #1;
    chk("b2b_idle_cycles", last_gap, 1);
    wait_idle(lat);
    chk("lat_ff", lat, FB * CPB);
    repeat (2) @(posedge clk);
    #1;

    // ena stall during data bit 3
    send(8'h3C, 1'b0);
    fork
      wait_idle(lat);
      begin
        repeat (17) @(posedge clk);
        #1 ena = 1'b0;
        chk("stall_ready", tx_ready, 1'b0);
        chk("stall_line_in", tx_line, 1'b1);
        repeat (7) @(posedge clk);
        chk("stall_line_out", tx_line, 1'b1);
        #1 ena = 1'b1;
      end
    join
    chk("lat_stall", lat, FB * CPB + 7);
    repeat (2) @(posedge clk);
    #1;

    // clr during data bit 5 drops the frame
    send(8'h96, 1'b0);
    repeat (25) @(posedge clk);
    #2 clr = 1'b1;
    #1;
    chk("clr_line", tx_line, 1'b1);
    chk("clr_busy", busy, 1'b0);
    exp_q.delete(0);
    sent--;
    @(posedge clk);
    #1 clr = 1'b0;
    send(8'h5A, 1'b0);
    wait_idle(lat);
    chk("lat_5a", lat, FB * CPB);

`ifdef SERIAL_TX_PARITY_EN
    send(8'hA5, 1'b0);
    wait_idle(lat);
    @(negedge clk);
    chk("par_a5", last_bits[DW+1], 1'b0);
    chk("lat_par", lat, 44);
    send(8'h07, 1'b0);
    wait_idle(lat);
    @(negedge clk);
    chk("par_07", last_bits[DW+1], 1'b1);
    #1;
`endif

    // tx_valid while busy is ignored
    send(8'h33, 1'b0);
    repeat (5) @(posedge clk);
    #1;
    tx_data  = 8'h11;
    tx_valid = 1'b1;
    repeat (10) @(posedge clk);
    #1 tx_valid = 1'b0;
    wait_idle(lat);
    chk("lat_ignore", lat, FB * CPB - 15);
    repeat (4) @(posedge clk);
    #1;
    chk("no_extra_frame", busy, 1'b0);

    // randomized words, random spacing
    for (int i = 0; i < 20; i++) begin
      keep = (i < 19) && ($urandom_range(0, 1) == 1);
      send(DW'($urandom), keep);
      if (!keep) begin
        repeat ($urandom_range(0, 3)) @(posedge clk);
        #1;
      end
    end

    t = 0;
    while ((exp_q.size() != 0 || busy) && t < 5000) begin
      @(posedge clk);
      #1;
      t++;
    end
    chk("drain_queue", exp_q.size(), 0);
    repeat (3) @(posedge clk);
    #1;
    chk("frames_done", done, sent);

    $display("== %0d vectors applied, %0d miscompares ==", vectors,
             miscompares);
    $finish;
  end

endmodule
